conversion_bcd_a_binario: RTL and testbench

- Sequential BCD-to-binary converter for the five RTC time/date fields: seconds, minutes, day, month, year.
- Sits on the read path after the RTC bus interface has captured the chip's BCD registers. Feeds binary values to the clock/date editing logic.
- This is the inverse of the existing binary-to-BCD conversion on the write path.
- Converts the five fields serially, each with a shift-add multiply-by-10. Results are published atomically with a start/done handshake.

---
 rtl/conversion_bcd_a_binario.sv | 175 +++++++++++++++++
 tb/tb_conversion_bcd_a_binario.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conversion_bcd_a_binario.sv
// ---------------------------------------------------------------------------
// conversion_bcd_a_binario
//
// Converts the five BCD time/date fields read from the RTC into binary, one
// field at a time. Each field takes two cycles: the first forms tens*8, the
// second adds tens*2 and the units digit. When all five fields are done, the
// results are published together in a single cycle. A start/done handshake
// frames each conversion.
//
// Ports:
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   start     request pulse, sampled only while idle
//   S,M,D,ME,A  BCD inputs: seconds, minutes, day, month, year
//   s,m,d,me,a  binary outputs, updated only when all fields are done
//   busy      high while a conversion is in progress
//   done      one-cycle pulse in the cycle the outputs change
//   err_mask  per-field illegal-digit flags (bit0 = S ... bit4 = A)
//   error     OR of err_mask
// ---------------------------------------------------------------------------
module conversion_bcd_a_binario #(
    parameter bit VALIDAR = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] S,
    input  logic [7:0] M,
    input  logic [7:0] D,
    input  logic [7:0] ME,
    input  logic [7:0] A,
    output logic [7:0] s,
    output logic [7:0] m,
    output logic [7:0] d,
    output logic [7:0] me,
    output logic [7:0] a,
    output logic       busy,
    output logic       done,
    output logic [4:0] err_mask,
    output logic       error
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] FASE_A   = 2'd1;
    localparam logic [1:0] FASE_B   = 2'd2;
    localparam logic [1:0] PUBLICAR = 2'd3;

    logic [1:0] state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] bcd_in [5];
    logic [7:0] shadow_q [5];
    logic [7:0] shadow_d [5];
    logic [7:0] work_q [5];
    logic [7:0] work_d [5];
    logic [7:0] out_q [5];
    logic [7:0] out_d [5];
    // tens*8 peaks at 120, so eight bits are enough for the partial product.
    logic [7:0] acc_q, acc_d;
    logic [4:0] err_w_q, err_w_d;
    logic [4:0] err_mask_q, err_mask_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [3:0] tens;
    logic [3:0] units;
    logic [7:0] res;

    assign bcd_in[0] = S;
    assign bcd_in[1] = M;
    assign bcd_in[2] = D;
    assign bcd_in[3] = ME;
    assign bcd_in[4] = A;

    assign tens  = shadow_q[idx_q][7:4];
    assign units = shadow_q[idx_q][3:0];
    // Maximum is 15*10+15 = 165, which still fits in eight bits.
    assign res   = acc_q + {3'b000, tens, 1'b0} + {4'b0000, units};

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shadow_d   = shadow_q;
        work_d     = work_q;
        out_d      = out_q;
        acc_d      = acc_q;
        err_w_d    = err_w_q;
        err_mask_d = err_mask_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shadow_d = bcd_in;
                    err_w_d  = 5'b00000;
                    idx_d    = 3'd0;
                    busy_d   = 1'b1;
                    state_d  = FASE_A;
                end
            end
            FASE_A: begin
                acc_d = {1'b0, tens, 3'b000};
                if (VALIDAR && ((tens > 4'd9) || (units > 4'd9))) begin
                    err_w_d[idx_q] = 1'b1;
                end
                state_d = FASE_B;
            end
            FASE_B: begin
                // A field with an illegal digit keeps its last published value.
                if (err_w_q[idx_q]) begin
                    work_d[idx_q] = out_q[idx_q];
                end else begin
                    work_d[idx_q] = res;
                end
                if (idx_q == 3'd4) begin
                    state_d = PUBLICAR;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = FASE_A;
                end
            end
            PUBLICAR: begin
                out_d      = work_q;
                err_mask_d = err_w_q;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            idx_q      <= 3'd0;
            acc_q      <= 8'd0;
            err_w_q    <= 5'b00000;
            err_mask_q <= 5'b00000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                shadow_q[i] <= 8'd0;
                work_q[i]   <= 8'd0;
                out_q[i]    <= 8'd0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            err_w_q    <= err_w_d;
            err_mask_q <= err_mask_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            for (int i = 0; i < 5; i++) begin
                shadow_q[i] <= shadow_d[i];
                work_q[i]   <= work_d[i];
                out_q[i]    <= out_d[i];
            end
        end
    end

    assign s        = out_q[0];
    assign m        = out_q[1];
    assign d        = out_q[2];
    assign me       = out_q[3];
    assign a        = out_q[4];
    assign busy     = busy_q;
    assign done     = done_q;
    assign err_mask = err_mask_q;
    assign error    = |err_mask_q;

endmodule

// File: tb/tb_conversion_bcd_a_binario.sv
module tb_conversion_bcd_a_binario;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] S, M, D, ME, A;

    logic [7:0] s1, m1, d1, me1, a1;
    logic       busy1, done1, error1;
    logic [4:0] err_mask1;
    logic [7:0] s0, m0, d0, me0, a0;
    logic       busy0, done0, error0;
    logic [4:0] err_mask0;

    int total = 0;
    int bad   = 0;

    // Reference state: last published value per field for each variant.
    int model1 [5];
    int model0 [5];

    always #5 clk = ~clk;

    conversion_bcd_a_binario #(.VALIDAR(1'b1)) dut_val (
        .clk(clk), .reset_n(reset_n), .start(start),
        .S(S), .M(M), .D(D), .ME(ME), .A(A),
        .s(s1), .m(m1), .d(d1), .me(me1), .a(a1),
        .busy(busy1), .done(done1), .err_mask(err_mask1), .error(error1)
    );

    conversion_bcd_a_binario #(.VALIDAR(1'b0)) dut_noval (
        .clk(clk), .reset_n(reset_n), .start(start),
        .S(S), .M(M), .D(D), .ME(ME), .A(A),
        .s(s0), .m(m0), .d(d0), .me(me0), .a(a0),
        .busy(busy0), .done(done0), .err_mask(err_mask0), .error(error0)
    );

    function automatic int get1(input int i);
        case (i)
            0: return int'(s1);
            1: return int'(m1);
            2: return int'(d1);
            3: return int'(me1);
            default: return int'(a1);
        endcase
    endfunction

    function automatic int get0(input int i);
        case (i)
            0: return int'(s0);
            1: return int'(m0);
            2: return int'(d0);
            3: return int'(me0);
            default: return int'(a0);
        endcase
    endfunction

    // One conversion from the caller's negedge: drive inputs, raise start,
    // follow the handshake, then compare against the digit-by-digit model.
    task automatic run_one(input logic [7:0] f0, f1, f2, f3, f4,
                           input bit hold, input bit disturb);
        int fld [5];
        int exp1 [5];
        int exp0 [5];
        int em1;
        int busy_cnt;
        int done_k;
        int done_cnt;
        int tn, un;
        fld[0] = f0; fld[1] = f1; fld[2] = f2; fld[3] = f3; fld[4] = f4;
        em1 = 0;
        for (int i = 0; i < 5; i++) begin
            tn = fld[i] / 16;
            un = fld[i] % 16;
            exp0[i] = tn * 10 + un;
            if (tn > 9 || un > 9) begin
                exp1[i] = model1[i];
                em1 = em1 | (1 << i);
            end else begin
                exp1[i] = tn * 10 + un;
            end
        end
        S = f0; M = f1; D = f2; ME = f3; A = f4;
        start = 1'b1;
        busy_cnt = 0; done_k = 0; done_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (disturb && k == 4) begin
                S = 8'($urandom); M = 8'($urandom); D = 8'($urandom);
                ME = 8'($urandom); A = 8'($urandom);
                start = 1'b1;
            end
            if (busy1) busy_cnt++;
            if (done1 !== done0 || busy1 !== busy0) begin
                total++; bad++;
                $display("FAIL handshake_match k=%0d got done=%b/%b busy=%b/%b want equal",
                         k, done1, done0, busy1, busy0);
            end
            if (done1) begin
                done_cnt++;
                done_k = k;
                break;
            end
        end
        total++;
        if (done_k !== 12 || done_cnt !== 1) begin
            bad++;
            $display("FAIL done_latency got k=%0d count=%0d want k=12 count=1", done_k, done_cnt);
        end
        total++;
        if (busy_cnt !== 11) begin
            bad++;
            $display("FAIL busy_cycles got %0d want 11", busy_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (get1(i) !== exp1[i]) begin
                bad++;
                $display("FAIL field%0d_validar got %0d want %0d (bcd %02h)", i, get1(i), exp1[i], fld[i]);
            end
            total++;
            if (get0(i) !== exp0[i]) begin
                bad++;
                $display("FAIL field%0d_novalidar got %0d want %0d (bcd %02h)", i, get0(i), exp0[i], fld[i]);
            end
            model1[i] = exp1[i];
            model0[i] = exp0[i];
        end
        total++;
        if (int'(err_mask1) !== em1 || error1 !== (em1 != 0)) begin
            bad++;
            $display("FAIL err_mask_validar got %b/%b want %05b/%0d", err_mask1, error1, em1[4:0], em1 != 0);
        end
        total++;
        if (err_mask0 !== 5'b00000 || error0 !== 1'b0) begin
            bad++;
            $display("FAIL err_mask_novalidar got %b/%b want 00000/0", err_mask0, error0);
        end
        $display("conv in=%02h %02h %02h %02h %02h out=%0d %0d %0d %0d %0d err=%b",
                 f0, f1, f2, f3, f4, s1, m1, d1, me1, a1, err_mask1);
    endtask

    task automatic check_zero_idle(input string tag);
        total++;
        if ({s1, m1, d1, me1, a1, s0, m0, d0, me0, a0} !== 80'd0 ||
            busy1 !== 1'b0 || busy0 !== 1'b0 || err_mask1 !== 5'd0 || err_mask0 !== 5'd0) begin
            bad++;
            $display("FAIL %s got s=%0d m=%0d d=%0d me=%0d a=%0d busy=%b err=%b want all 0",
                     tag, s1, m1, d1, me1, a1, busy1, err_mask1);
        end
    endtask

    task automatic no_done_for(input int n, input string tag);
        int seen;
        seen = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (done1 || done0) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL %s got %0d done pulses want 0", tag, seen);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0;
        S = 8'h00; M = 8'h00; D = 8'h00; ME = 8'h00; A = 8'h00;
        for (int i = 0; i < 5; i++) begin model1[i] = 0; model0[i] = 0; end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check_zero_idle("reset_state");
        no_done_for(10, "reset_idle_done");
        check_zero_idle("reset_idle_state");
        $display("reset: outputs=%0d busy=%b", s1, busy1);
    endtask

    task automatic test_nominal();
        run_one(8'h59, 8'h30, 8'h31, 8'h12, 8'h16, 1'b0, 1'b0);
        @(negedge clk);
        total++;
        if (done1 !== 1'b0) begin
            bad++;
            $display("FAIL done_width got %b want 0", done1);
        end
    endtask

    task automatic test_invalid();
        run_one(8'h5A, 8'hF0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        run_one(8'h2B, 8'h45, 8'hC3, 8'h07, 8'h9F, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            logic [7:0] r [5];
            for (int i = 0; i < 5; i++) begin
                if ($urandom_range(0, 3) == 0) r[i] = 8'($urandom);
                else r[i] = 8'(($urandom_range(0, 9) << 4) | $urandom_range(0, 9));
            end
            run_one(r[0], r[1], r[2], r[3], r[4], 1'b0, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic test_boundary_ignored();
        run_one(8'h99, 8'h99, 8'h99, 8'h99, 8'h99, 1'b0, 1'b1);
        start = 1'b0;
        no_done_for(20, "ignored_start_done");
        total++;
        if (s1 !== 8'd99 || a1 !== 8'd99 || me0 !== 8'd99) begin
            bad++;
            $display("FAIL boundary_hold got s=%0d a=%0d me0=%0d want 99", s1, a1, me0);
        end
    endtask

    task automatic test_mid_reset();
        S = 8'h12; M = 8'h34; D = 8'h25; ME = 8'h11; A = 8'h88;
        start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        check_zero_idle("midreset_clear");
        for (int i = 0; i < 5; i++) begin model1[i] = 0; model0[i] = 0; end
        @(negedge clk);
        reset_n = 1'b1;
        no_done_for(20, "midreset_no_done");
        check_zero_idle("midreset_after");
        $display("midreset: busy=%b s=%0d", busy1, s1);
    endtask

    task automatic test_back_to_back();
        run_one(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 1'b1, 1'b0);
        run_one(8'h47, 8'h58, 8'h29, 8'h10, 8'h99, 1'b1, 1'b0);
        run_one(8'h00, 8'hE5, 8'h19, 8'h08, 8'h42, 1'b1, 1'b0);
        start = 1'b0;
        no_done_for(14, "b2b_stop");
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_invalid();
        test_random();
        test_boundary_ignored();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
